// File: rtl/ifm_rxs_seq.sv
// Per-frame sequencer: pops one descriptor, emits the rxs status frame, then
// releases exactly one data frame on rxd and checks its byte count.
module ifm_rxs_seq #(
    parameter int          C_STS_WORDS = 6,
    parameter logic [31:0] C_FLAG_WORD = 32'h5000_0000
) (
    input  logic        s2mm_clk,
    input  logic        s2mm_resetn,
    input  logic [36:0] desc_data,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [63:0] rxd_in_tdata,
    input  logic [7:0]  rxd_in_tkeep,
    input  logic        rxd_in_tlast,
    input  logic        rxd_in_tvalid,
    output logic        rxd_in_tready,
    output logic [63:0] rxd_tdata,
    output logic [7:0]  rxd_tkeep,
    output logic        rxd_tlast,
    output logic        rxd_tvalid,
    input  logic        rxd_tready,
    output logic [31:0] rxs_tdata,
    output logic [3:0]  rxs_tkeep,
    output logic        rxs_tlast,
    output logic        rxs_tvalid,
    input  logic        rxs_tready,
    output logic [31:0] frame_cnt,
    output logic        len_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STS  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(C_STS_WORDS - 1);

    state_t      state_r;
    state_t      state_s;
    logic [36:0] desc_r;
    logic [3:0]  word_idx_r;
    logic [16:0] acc_r;
    logic [31:0] frame_cnt_r;
    logic        len_err_r;
    logic [31:0] rxs_tdata_r;
    logic [3:0]  rxs_tkeep_r;
    logic        rxs_tlast_r;
    logic        rxs_tvalid_r;

    logic        desc_acc_s;
    logic        sts_hs_s;
    logic        sts_last_s;
    logic        in_data_s;
    logic        beat_hs_s;
    logic        frame_end_s;
    logic [16:0] final_sum_s;

    function automatic logic [3:0] popcount8(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

    function automatic logic [31:0] sts_word(input logic [3:0] idx, input logic [36:0] d);
        logic [31:0] w;
        case (idx)
            4'd0:    w = C_FLAG_WORD;
            4'd1:    w = {27'd0, d[36:32]};
            4'd2:    w = {16'd0, d[31:16]};
            4'd4:    w = {16'd0, d[15:0]};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    assign desc_ready  = (state_r == ST_IDLE);
    assign desc_acc_s  = desc_ready && desc_valid;
    assign sts_hs_s    = rxs_tvalid_r && rxs_tready;
    assign sts_last_s  = sts_hs_s && (word_idx_r == LAST_IDX);
    assign in_data_s   = (state_r == ST_DATA);
    assign beat_hs_s   = in_data_s && rxd_in_tvalid && rxd_tready;
    assign frame_end_s = beat_hs_s && rxd_in_tlast;
    assign final_sum_s = acc_r + {13'd0, popcount8(rxd_in_tkeep)};

    // Data stream is a gated pass-through of the good FIFO while in DATA.
    assign rxd_tdata     = rxd_in_tdata;
    assign rxd_tkeep     = rxd_in_tkeep;
    assign rxd_tlast     = rxd_in_tlast;
    assign rxd_tvalid    = in_data_s && rxd_in_tvalid;
    assign rxd_in_tready = in_data_s && rxd_tready;

    assign rxs_tdata  = rxs_tdata_r;
    assign rxs_tkeep  = rxs_tkeep_r;
    assign rxs_tlast  = rxs_tlast_r;
    assign rxs_tvalid = rxs_tvalid_r;
    assign frame_cnt  = frame_cnt_r;
    assign len_err    = len_err_r;

    // State register.
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a zero-length descriptor skips the data phase.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (desc_valid) state_s = ST_STS;
                else            state_s = ST_IDLE;
            end
            ST_STS: begin
                if (sts_last_s) state_s = (desc_r[15:0] == 16'd0) ? ST_IDLE : ST_DATA;
                else            state_s = ST_STS;
            end
            ST_DATA: begin
                if (frame_end_s) state_s = ST_IDLE;
                else             state_s = ST_DATA;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Status word generator; word k+1 is preloaded on the handshake of word k.
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            desc_r       <= 37'd0;
            word_idx_r   <= 4'd0;
            rxs_tvalid_r <= 1'b0;
            rxs_tdata_r  <= 32'd0;
            rxs_tkeep_r  <= 4'd0;
            rxs_tlast_r  <= 1'b0;
        end else if (desc_acc_s) begin
            desc_r       <= desc_data;
            word_idx_r   <= 4'd0;
            rxs_tvalid_r <= 1'b1;
            rxs_tdata_r  <= sts_word(4'd0, desc_data);
            rxs_tkeep_r  <= 4'hF;
            rxs_tlast_r  <= 1'b0;
        end else if (sts_last_s) begin
            rxs_tvalid_r <= 1'b0;
            rxs_tdata_r  <= 32'd0;
            rxs_tkeep_r  <= 4'd0;
            rxs_tlast_r  <= 1'b0;
        end else if (sts_hs_s) begin
            word_idx_r  <= word_idx_r + 4'd1;
            rxs_tdata_r <= sts_word(word_idx_r + 4'd1, desc_r);
            rxs_tlast_r <= ((word_idx_r + 4'd1) == LAST_IDX);
        end
    end

    // Byte accounting, delivered-frame counter and length-mismatch pulse.
    always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
        if (!s2mm_resetn) begin
            acc_r       <= 17'd0;
            frame_cnt_r <= 32'd0;
            len_err_r   <= 1'b0;
        end else begin
            len_err_r <= frame_end_s && (final_sum_s != {1'b0, desc_r[15:0]});
            if (desc_acc_s) begin
                acc_r <= 17'd0;
            end else if (beat_hs_s) begin
                acc_r <= final_sum_s;
            end
            if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifm_rxs_seq.sv
// Randomized self-checking bench for ifm_rxs_seq against a frame-level model.
module tb_ifm_rxs_seq;

    localparam int NW = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [36:0] desc_data;
    logic        desc_valid;
    logic        desc_ready;
    logic [63:0] rxd_in_tdata;
    logic [7:0]  rxd_in_tkeep;
    logic        rxd_in_tlast;
    logic        rxd_in_tvalid;
    logic        rxd_in_tready;
    logic [63:0] rxd_tdata;
    logic [7:0]  rxd_tkeep;
    logic        rxd_tlast;
    logic        rxd_tvalid;
    logic        rxd_tready;
    logic [31:0] rxs_tdata;
    logic [3:0]  rxs_tkeep;
    logic        rxs_tlast;
    logic        rxs_tvalid;
    logic        rxs_tready;
    logic [31:0] frame_cnt;
    logic        len_err;

    always #5 clk = ~clk;

    ifm_rxs_seq #(.C_STS_WORDS(NW), .C_FLAG_WORD(32'h5000_0000)) dut (
        .s2mm_clk(clk), .s2mm_resetn(rst_n),
        .desc_data(desc_data), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .rxd_in_tdata(rxd_in_tdata), .rxd_in_tkeep(rxd_in_tkeep), .rxd_in_tlast(rxd_in_tlast),
        .rxd_in_tvalid(rxd_in_tvalid), .rxd_in_tready(rxd_in_tready),
        .rxd_tdata(rxd_tdata), .rxd_tkeep(rxd_tkeep), .rxd_tlast(rxd_tlast),
        .rxd_tvalid(rxd_tvalid), .rxd_tready(rxd_tready),
        .rxs_tdata(rxs_tdata), .rxs_tkeep(rxs_tkeep), .rxs_tlast(rxs_tlast),
        .rxs_tvalid(rxs_tvalid), .rxs_tready(rxs_tready),
        .frame_cnt(frame_cnt), .len_err(len_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus queues: control FIFO, good-data FIFO, and per-frame expectations.
    logic [36:0] desc_q[$];
    logic [72:0] beat_q[$];
    int          nb_q[$];
    bit          err_q[$];

    // Frame-level model state.
    int          sts_out = 0;
    int          widx    = 0;
    int          dat_out = 0;
    logic [36:0] cur_desc = 37'd0;
    bit          cur_err  = 1'b0;
    bit          pend_err = 1'b0;
    logic [31:0] fcnt     = 32'd0;
    int          mode     = 0;
    bit          tog      = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [36:0] d, input int k);
        if (k == 0) return 32'h5000_0000;
        if (k == 1) return {27'd0, d[36:32]};
        if (k == 2) return {16'd0, d[31:16]};
        if (k == 4) return {16'd0, d[15:0]};
        return 32'd0;
    endfunction

    task automatic add_frame(input logic [15:0] len, input logic [4:0] flags,
                             input logic [15:0] csum, input int nb, input logic [7:0] lastkeep);
        int         sum;
        logic [7:0] keep;
        sum = 0;
        desc_q.push_back({flags, csum, len});
        for (int i = 0; i < nb; i++) begin
            keep = (i == nb - 1) ? lastkeep : 8'hFF;
            sum += $countones(keep);
            beat_q.push_back({(i == nb - 1), keep, $urandom(), $urandom()});
        end
        nb_q.push_back(nb);
        err_q.push_back((nb != 0) && (sum != int'(len)));
    endtask

    task automatic add_random_frame();
        int         nb, lb, sum;
        logic [7:0] ff;
        logic [15:0] len;
        ff = 8'hFF;
        if ($urandom_range(0, 7) == 0) begin
            add_frame(16'd0, 5'($urandom()), 16'($urandom()), 0, 8'h00);
        end else begin
            nb  = $urandom_range(1, 10);
            lb  = $urandom_range(1, 8);
            sum = (nb - 1) * 8 + lb;
            len = 16'(sum);
            if ($urandom_range(0, 3) == 0) len = 16'(sum + $urandom_range(1, 3));
            add_frame(len, 5'($urandom()), 16'($urandom()), nb, ff >> (8 - lb));
        end
    endtask

    // One clock: drive at the falling edge, check and advance the model before the rising edge.
    task automatic step();
        bit          idle, dph;
        logic [72:0] b;
        @(negedge clk);
        tog = ~tog;
        case (mode)
            1:       begin rxs_tready = tog; rxd_tready = ($urandom_range(0, 3) != 0); end
            2:       begin rxs_tready = 1'b1; rxd_tready = 1'b1; end
            default: begin rxs_tready = ($urandom_range(0, 3) != 0); rxd_tready = ($urandom_range(0, 3) != 0); end
        endcase
        desc_valid = (desc_q.size() > 0) && ((mode == 2) || ($urandom_range(0, 3) != 0));
        desc_data  = (desc_q.size() > 0) ? desc_q[0] : 37'({$urandom(), $urandom()});
        if ((beat_q.size() > 0) && ((mode == 2) || ($urandom_range(0, 4) != 0))) begin
            {rxd_in_tlast, rxd_in_tkeep, rxd_in_tdata} = beat_q[0];
            rxd_in_tvalid = 1'b1;
        end else begin
            {rxd_in_tlast, rxd_in_tkeep, rxd_in_tdata} = {$urandom(), $urandom(), $urandom()};
            rxd_in_tvalid = 1'b0;
        end
        #1;
        idle = (sts_out == 0) && (dat_out == 0);
        dph  = (sts_out == 0) && (dat_out > 0);
        check_val("desc_ready", desc_ready, idle);
        check_val("rxs_tvalid", rxs_tvalid, sts_out > 0);
        if (sts_out > 0) begin
            check_val("rxs_tdata", rxs_tdata, exp_word(cur_desc, widx));
            check_val("rxs_tlast", rxs_tlast, widx == NW - 1);
            check_val("rxs_tkeep", rxs_tkeep, 4'hF);
        end
        check_val("rxd_in_tready", rxd_in_tready, dph && rxd_tready);
        check_val("rxd_tvalid", rxd_tvalid, dph && rxd_in_tvalid);
        check_val("len_err", len_err, pend_err);
        check_val("frame_cnt", frame_cnt, fcnt);
        pend_err = 1'b0;
        if (idle && desc_valid) begin
            cur_desc = desc_q.pop_front();
            dat_out  = nb_q.pop_front();
            cur_err  = err_q.pop_front();
            sts_out  = NW;
            widx     = 0;
        end else if ((sts_out > 0) && rxs_tready) begin
            sts_out--;
            widx++;
        end else if (dph && rxd_in_tvalid && rxd_tready) begin
            b = beat_q.pop_front();
            check_val("rxd_beat", {rxd_tlast, rxd_tkeep, rxd_tdata}, b);
            dat_out--;
            if (b[72]) begin
                pend_err = cur_err;
                fcnt     = fcnt + 32'd1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (((desc_q.size() > 0) || (sts_out > 0) || (dat_out > 0)) && (c < budget)) begin
            step();
            c++;
        end
        check_val("drain_left", desc_q.size() + sts_out + dat_out, 0);
        step();
        step();
    endtask

    task automatic check_reset_outputs();
        check_val("rst_desc_ready", desc_ready, 1'b1);
        check_val("rst_rxs", {rxs_tvalid, rxs_tlast, rxs_tkeep, rxs_tdata}, 38'd0);
        check_val("rst_rxd_tvalid", rxd_tvalid, 1'b0);
        check_val("rst_rxd_in_tready", rxd_in_tready, 1'b0);
        check_val("rst_frame_cnt", frame_cnt, 32'd0);
        check_val("rst_len_err", len_err, 1'b0);
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        desc_valid = 1'b0; desc_data = 37'd0;
        rxd_in_tvalid = 1'b0; rxd_in_tdata = 64'd0; rxd_in_tkeep = 8'd0; rxd_in_tlast = 1'b0;
        rxs_tready = 1'b1; rxd_tready = 1'b1;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        mode = 2;
        add_frame(16'd64, 5'b00001, 16'hABCD, 8, 8'hFF);
        drain(200);

        mode = 0;
        add_frame(16'd61, 5'b00010, 16'h1234, 8, 8'h1F);
        add_frame(16'd60, 5'b00100, 16'h4321, 8, 8'h1F);
        drain(1000);

        mode = 1;
        add_frame(16'd16, 5'b01000, 16'h0F0F, 2, 8'hFF);
        add_frame(16'd0,  5'b10000, 16'h5555, 0, 8'h00);
        add_frame(16'd8,  5'b00011, 16'hBEEF, 1, 8'hFF);
        drain(1000);

        mode = 2;
        add_frame(16'd24, 5'b00101, 16'h1111, 3, 8'hFF);
        add_frame(16'd13, 5'b01010, 16'h2222, 2, 8'h1F);
        drain(200);

        // Abort mid-DATA, then require a clean restart.
        add_frame(16'd64, 5'b00001, 16'hCAFE, 8, 8'hFF);
        c = 0;
        while ((dat_out != 5) && (c < 200)) begin
            step();
            c++;
        end
        check_val("reach_beat3", dat_out, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        desc_q.delete(); beat_q.delete(); nb_q.delete(); err_q.delete();
        sts_out = 0; dat_out = 0; widx = 0; pend_err = 1'b0; fcnt = 32'd0;
        desc_valid = 1'b0; rxd_in_tvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        mode = 0;
        for (int i = 0; i < 30; i++) add_random_frame();
        drain(6000);
        mode = 1;
        for (int i = 0; i < 10; i++) add_random_frame();
        drain(3000);
        mode = 2;
        for (int i = 0; i < 6; i++) add_random_frame();
        drain(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
